// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the SPI command controller.
package spi_cmd_ctrl_pkg;

  localparam logic [7:0] OpWrite  = 8'h01;
  localparam logic [7:0] OpRead   = 8'h02;
  localparam logic [7:0] OpStatus = 8'h03;

  localparam int unsigned ErrCntW = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmd     = 3'd1,
    StAddr    = 3'd2,
    StWr      = 3'd3,
    StRd      = 3'd4,
    StStat    = 3'd5,
    StDiscard = 3'd6
  } state_e;

  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] val);
    return (&val) ? val : val + ErrCntW'(1);
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_ss_sync_edge.sv
// Two-flop synchroniser for the raw SPI select pin with single-cycle rise/fall pulses.
module spi_cmd_ctrl_ss_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ss,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_ss;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI frame parser: decodes CMD/ADDR/payload, drives auto-incrementing register writes,
// prefetched reads and status replies, and counts bad frames.
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ss,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_load,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [7:0]         o_wr_data,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [7:0]         i_rd_data,
  output logic               o_busy,
  output logic [ErrCntW-1:0] o_err_cnt
);

  logic w_ss_rise;
  logic w_ss_fall;

  spi_cmd_ctrl_ss_sync_edge u_ss_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ss    (i_ss),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  state_e              r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic                r_is_rd,     w_is_rd_nxt;
  logic [ErrCntW-1:0]  r_err_cnt,   w_err_cnt_nxt;
  logic                r_hist,      w_hist_nxt;
  logic                r_stat_pend, w_stat_pend_nxt;
  logic [7:0]          r_tx_data,   w_tx_data_nxt;
  logic                r_tx_load,   w_tx_load_nxt;
  logic                r_wr_en,     w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr,   w_wr_addr_nxt;
  logic [7:0]          r_wr_data,   w_wr_data_nxt;
  logic                r_rd_en,     w_rd_en_nxt;
  logic [ADDR_W-1:0]   r_rd_addr,   w_rd_addr_nxt;
  logic [RD_LAT-1:0]   r_vpipe;
  logic [RD_LAT:0]     w_vchain;
  logic                w_rd_valid;
  logic [ADDR_W-1:0]   w_rx_addr;

  // Read-strobe delay line; its far end marks the cycle rd_data is valid.
  assign w_vchain   = {r_vpipe, r_rd_en};
  assign w_rd_valid = w_vchain[RD_LAT];
  assign w_rx_addr  = ADDR_W'(i_rx_data);

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_is_rd_nxt     = r_is_rd;
    w_err_cnt_nxt   = r_err_cnt;
    w_hist_nxt      = r_hist;
    w_stat_pend_nxt = r_stat_pend;
    w_tx_data_nxt   = r_tx_data;
    w_tx_load_nxt   = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = r_rd_addr;

    case (r_state)
      StIdle: begin
        if (w_ss_rise) w_state_nxt = StCmd;
      end
      StCmd: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            OpWrite: begin
              w_state_nxt = StAddr;
              w_is_rd_nxt = 1'b0;
            end
            OpRead: begin
              w_state_nxt = StAddr;
              w_is_rd_nxt = 1'b1;
            end
            OpStatus: begin
              w_state_nxt     = StStat;
              w_stat_pend_nxt = 1'b1;
            end
            default: begin
              w_state_nxt   = StDiscard;
              w_err_cnt_nxt = sat_inc(r_err_cnt);
            end
          endcase
        end
      end
      StAddr: begin
        if (i_rx_valid) begin
          w_addr_nxt = w_rx_addr;
          if (r_is_rd) begin
            w_state_nxt   = StRd;
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_rx_addr;
          end else begin
            w_state_nxt = StWr;
          end
        end
      end
      StWr: begin
        if (i_rx_valid) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_addr;
          w_wr_data_nxt = i_rx_data;
          w_addr_nxt    = r_addr + ADDR_W'(1);
        end
      end
      StRd: begin
        // Host dummy bytes arrive well after the previous load, so these never overlap.
        if (i_rx_valid) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_addr;
        end
        if (w_rd_valid) begin
          w_tx_data_nxt = i_rd_data;
          w_tx_load_nxt = 1'b1;
          w_addr_nxt    = r_addr + ADDR_W'(1);
        end
      end
      StStat: begin
        if (r_stat_pend) begin
          w_tx_data_nxt   = {r_hist, 3'b000, r_err_cnt[3:0]};
          w_tx_load_nxt   = 1'b1;
          w_stat_pend_nxt = 1'b0;
        end
      end
      StDiscard: ;
      default: w_state_nxt = StIdle;
    endcase

    // Frame end wins after the current byte has been processed; ending while still
    // waiting for the address byte is a truncated frame.
    if (w_ss_fall) begin
      if (w_state_nxt == StAddr) begin
        w_err_cnt_nxt = sat_inc(w_err_cnt_nxt);
        w_hist_nxt    = 1'b1;
      end
      w_state_nxt     = StIdle;
      w_stat_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_is_rd     <= 1'b0;
      r_err_cnt   <= '0;
      r_hist      <= 1'b0;
      r_stat_pend <= 1'b0;
      r_tx_data   <= '0;
      r_tx_load   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_vpipe     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_is_rd     <= w_is_rd_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_hist      <= w_hist_nxt;
      r_stat_pend <= w_stat_pend_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_load   <= w_tx_load_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_vpipe     <= w_vchain[RD_LAT-1:0];
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_load = r_tx_load;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_busy    = (r_state != StIdle);
  assign o_err_cnt = r_err_cnt;

endmodule
